// File: rtl/wb_cfg_bridge_if.sv
// Wishbone slave port bundle for the weight/bias configuration bridge.
interface wb_cfg_bridge_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_cfg_bridge.sv
// Wishbone config bridge: ADDR/CTRL/STATUS/DATA window driving N memory targets with
// one-cycle store strobes and latency-tracked loads captured back into DATA.
module wb_cfg_bridge #(
  parameter int          NUM_TGT            = 3,
  parameter int          TGT_BW             = 3,
  parameter int          BANK_BW            = 4,
  parameter int          ADDR_BW            = 8,
  parameter int          VECTOR_BW          = 104,
  parameter int          DATA_WORDS         = 4,
  parameter int          RD_LATENCY         = 1,
  parameter logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  wb_cfg_bridge_if.slave                 wb,
  output logic [NUM_TGT-1:0]             mem_rd_en_o,
  output logic [NUM_TGT-1:0]             mem_wr_en_o,
  output logic [BANK_BW-1:0]             mem_bank_o,
  output logic [ADDR_BW-1:0]             mem_addr_o,
  output logic [VECTOR_BW-1:0]           mem_wr_data_o,
  input  logic [NUM_TGT*VECTOR_BW-1:0]   mem_rd_data_i
);
  localparam int DW    = DATA_WORDS * 32;
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, STORE, LOAD, WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q;
  logic [31:0]        data_q [DATA_WORDS];
  logic               done_q, err_tgt_q, err_ovr_q;
  logic               ack_q;
  logic [31:0]        dat_q;

  logic               acc, in_win, wr, wr_addr, wr_ctrl, wr_stat, busy;
  logic [5:0]         widx;
  logic               cmd_store, cmd_load, tgt_ok;
  logic [TGT_BW-1:0]  tgt;
  logic [NUM_TGT-1:0] tgt_oh;
  logic [VECTOR_BW-1:0] rd_sel;
  logic [DW-1:0]      cap_vec, data_flat;
  logic [31:0]        status_vec, rd_mux;
  logic               set_done, set_err_tgt, capture;
  logic               unused_ok;

  // A new access is only taken once the previous ack has dropped.
  assign acc     = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q;
  assign in_win  = (wb.wbs_adr_i[31:8] == WISHBONE_BASE_ADDR[31:8]);
  assign widx    = wb.wbs_adr_i[7:2];
  assign wr      = acc & wb.wbs_we_i & in_win;
  assign wr_addr = wr && (widx == 6'd0);
  assign wr_ctrl = wr && (widx == 6'd1);
  assign wr_stat = wr && (widx == 6'd2);
  assign busy    = (state_q != IDLE);

  assign cmd_store = (wb.wbs_dat_i == 32'd1);
  assign cmd_load  = (wb.wbs_dat_i == 32'd2);
  assign tgt       = addr_q[ADDR_BW+BANK_BW +: TGT_BW];
  assign tgt_ok    = (32'(tgt) < NUM_TGT);

  assign mem_addr_o    = addr_q[ADDR_BW-1:0];
  assign mem_bank_o    = addr_q[ADDR_BW +: BANK_BW];
  assign mem_wr_data_o = VECTOR_BW'(data_flat);
  assign wb.wbs_ack_o  = ack_q;
  assign wb.wbs_dat_o  = dat_q;
  assign status_vec    = {28'd0, err_ovr_q, err_tgt_q, done_q, busy};
  assign unused_ok     = ^{wb.wbs_sel_i, wb.wbs_adr_i[1:0]};

  always_comb begin
    tgt_oh = '0;
    rd_sel = '0;
    for (int t = 0; t < NUM_TGT; t++) begin
      if (tgt == TGT_BW'(t)) begin
        tgt_oh[t] = 1'b1;
        rd_sel    = mem_rd_data_i[t*VECTOR_BW +: VECTOR_BW];
      end
    end
  end

  always_comb begin
    cap_vec                  = '0;
    cap_vec[VECTOR_BW-1:0]   = rd_sel;
    data_flat                = '0;
    for (int k = 0; k < DATA_WORDS; k++) data_flat[k*32 +: 32] = data_q[k];
  end

  always_comb begin
    rd_mux = '0;
    if (in_win) begin
      if (widx == 6'd0)      rd_mux = addr_q;
      else if (widx == 6'd2) rd_mux = status_vec;
      for (int k = 0; k < DATA_WORDS; k++)
        if (widx == 6'(4 + k)) rd_mux = data_q[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_rd_en_o = '0;
    mem_wr_en_o = '0;
    set_done    = 1'b0;
    set_err_tgt = 1'b0;
    capture     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_ctrl && (cmd_store || cmd_load)) begin
          if (!tgt_ok)        set_err_tgt = 1'b1;
          else if (cmd_store) state_d = STORE;
          else                state_d = LOAD;
        end
      end
      STORE: begin
        mem_wr_en_o = tgt_oh;
        set_done    = 1'b1;
        state_d     = IDLE;
      end
      LOAD: begin
        mem_rd_en_o = tgt_oh;
        cnt_d       = CNT_W'(RD_LATENCY - 1);
        state_d     = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          capture  = 1'b1;
          set_done = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky status bits: a set in the same cycle as a W1C wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      err_tgt_q <= 1'b0;
      err_ovr_q <= 1'b0;
      for (int k = 0; k < DATA_WORDS; k++) data_q[k] <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= acc ? rd_mux : '0;
      if (wr_addr && !busy) addr_q <= wb.wbs_dat_i;
      for (int k = 0; k < DATA_WORDS; k++) begin
        if (capture)
          data_q[k] <= cap_vec[k*32 +: 32];
        else if (wr && !busy && (widx == 6'(4 + k)))
          data_q[k] <= wb.wbs_dat_i;
      end
      done_q    <= (done_q    & ~(wr_stat & wb.wbs_dat_i[1])) | set_done;
      err_tgt_q <= (err_tgt_q & ~(wr_stat & wb.wbs_dat_i[2])) | set_err_tgt;
      err_ovr_q <= (err_ovr_q & ~(wr_stat & wb.wbs_dat_i[3])) | (wr_ctrl & busy);
    end
  end
endmodule

// File: tb/tb_wb_cfg_bridge.sv
// Directed bench for wb_cfg_bridge with RD_LATENCY=3 and three targets.
module tb_wb_cfg_bridge;
  localparam logic [31:0]  BASE = 32'h3000_0000;
  localparam logic [103:0] PAT0 = {26{4'hE}};
  localparam logic [103:0] PAT1 = 104'hC5_DEADBEEF_CAFEF00D_12345678;
  localparam logic [103:0] PAT2 = 104'h0F_0E0D0C0B_0A090807_06050403;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   rd_en, wr_en;
  logic [3:0]   bank;
  logic [7:0]   maddr;
  logic [103:0] wdata;
  logic [311:0] rdata;

  int total = 0, passed = 0, failed = 0;
  int wr_cnt = 0, rd_cnt = 0, ack_long = 0;
  logic ack_prev = 1'b0;
  logic [31:0] rv;

  wb_cfg_bridge_if wbif ();

  wb_cfg_bridge #(.RD_LATENCY(3)) dut (
    .clk_i(clk), .rst_i(rst), .wb(wbif),
    .mem_rd_en_o(rd_en), .mem_wr_en_o(wr_en), .mem_bank_o(bank),
    .mem_addr_o(maddr), .mem_wr_data_o(wdata), .mem_rd_data_i(rdata)
  );

  assign rdata = {PAT2, PAT1, PAT0};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en != 3'b000) wr_cnt++;
    if (rd_en != 3'b000) rd_cnt++;
    if (wbif.wbs_ack_o && ack_prev) ack_long++;
    ack_prev = wbif.wbs_ack_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] off, input logic [31:0] d,
                         input int idle, output logic [31:0] q);
    int n;
    repeat (idle) @(posedge clk);
    @(posedge clk); #1;
    wbif.wbs_stb_i = 1'b1; wbif.wbs_cyc_i = 1'b1; wbif.wbs_we_i = we;
    wbif.wbs_adr_i = BASE + off; wbif.wbs_dat_i = d;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!wbif.wbs_ack_o && n < 8);
    q = wbif.wbs_dat_o;
    wbif.wbs_stb_i = 1'b0; wbif.wbs_cyc_i = 1'b0; wbif.wbs_we_i = 1'b0;
    check("ack_latency", n, 1);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, off, d, 0, q);
  endtask

  task automatic rd(input logic [31:0] off, input int idle, output logic [31:0] q);
    wb_xfer(1'b0, off, 32'd0, idle, q);
  endtask

  initial begin
    logic [31:0] offs [10];
    offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h40};
    wbif.wbs_stb_i = 1'b0; wbif.wbs_cyc_i = 1'b0; wbif.wbs_we_i = 1'b0;
    wbif.wbs_sel_i = 4'hF; wbif.wbs_adr_i = '0; wbif.wbs_dat_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", wbif.wbs_ack_o, 0);
    check("rst_dat", wbif.wbs_dat_o, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_bank", bank, 0);
    check("rst_addr", maddr, 0);
    check("rst_wdata", wdata, 0);
    rst = 1'b0;
    foreach (offs[i]) begin
      rd(offs[i], 0, rv);
      check($sformatf("rst_read_%0h", offs[i]), rv, 0);
    end

    // Store: tgt 2, bank 1, word 0x13
    wr(32'h00, 32'h0000_2113);
    wr(32'h10, 32'h1111_1111);
    wr(32'h14, 32'h2222_2222);
    wr(32'h18, 32'h3333_3333);
    wr(32'h1C, 32'h0000_00AB);
    rd(32'h00, 0, rv); check("addr_readback", rv, 32'h2113);
    rd(32'h18, 0, rv); check("data2_readback", rv, 32'h3333_3333);
    check("store_bank", bank, 4'h1);
    check("store_addr", maddr, 8'h13);
    wr(32'h04, 32'd1);
    check("store_wr_en", wr_en, 3'b100);
    check("store_wdata", wdata, 104'hAB_33333333_22222222_11111111);
    check("store_rd_en", rd_en, 3'b000);
    rd(32'h04, 0, rv); check("ctrl_reads_0", rv, 0);
    rd(32'h08, 0, rv); check("store_status", rv, 32'h2);
    check("store_wr_pulses", wr_cnt, 1);
    wr(32'h08, 32'h2);
    rd(32'h08, 0, rv); check("w1c_done", rv, 0);

    // Illegal target 7
    wr(32'h00, 32'h0000_7000);
    wr(32'h04, 32'd1);
    check("illegal_wr_en", wr_en, 0);
    check("illegal_rd_en", rd_en, 0);
    rd(32'h08, 0, rv); check("illegal_status", rv, 32'h4);
    wr(32'h08, 32'h4);
    rd(32'h08, 0, rv); check("w1c_err_tgt", rv, 0);
    check("illegal_no_strobes", wr_cnt + rd_cnt, 1);

    // Load from target 1 with 3-cycle read latency
    wr(32'h00, 32'h0000_1240);
    wr(32'h04, 32'd2);
    check("load_rd_en", rd_en, 3'b010);
    check("load_wr_en", wr_en, 3'b000);
    rd(32'h08, 1, rv); check("load_busy_mid", rv, 32'h1);
    rd(32'h08, 0, rv); check("load_done", rv, 32'h2);
    check("load_rd_pulses", rd_cnt, 1);
    rd(32'h10, 0, rv); check("load_data0", rv, 32'h1234_5678);
    rd(32'h14, 0, rv); check("load_data1", rv, 32'hCAFE_F00D);
    rd(32'h18, 0, rv); check("load_data2", rv, 32'hDEAD_BEEF);
    rd(32'h1C, 0, rv); check("load_data3", rv, 32'h0000_00C5);
    wr(32'h08, 32'hE);
    rd(32'h08, 0, rv); check("w1c_all", rv, 0);

    // Overrun: store request and ADDR write land while the load is in WAIT
    wr(32'h00, 32'h0000_2000);
    wr(32'h04, 32'd2);
    wr(32'h04, 32'd1);
    wr(32'h00, 32'h0000_1000);
    rd(32'h08, 0, rv); check("ovr_status", rv, 32'hA);
    rd(32'h00, 0, rv); check("ovr_addr_dropped", rv, 32'h2000);
    rd(32'h10, 0, rv); check("ovr_data0", rv, 32'h0605_0403);
    rd(32'h1C, 0, rv); check("ovr_data3", rv, 32'h0000_000F);
    check("ovr_no_store", wr_cnt, 1);
    check("ovr_rd_pulses", rd_cnt, 2);

    // Reset while waiting on a load from target 1
    wr(32'h00, 32'h0000_1000);
    wr(32'h04, 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_rd_en", rd_en, 0);
    check("midrst_wr_en", wr_en, 0);
    rst = 1'b0;
    rd(32'h08, 0, rv); check("midrst_status", rv, 0);
    rd(32'h10, 0, rv); check("midrst_data0", rv, 0);
    rd(32'h1C, 0, rv); check("midrst_data3", rv, 0);
    rd(32'h00, 0, rv); check("midrst_addr", rv, 0);
    repeat (4) @(posedge clk);
    rd(32'h10, 0, rv); check("midrst_no_capture", rv, 0);

    check("ack_one_cycle", ack_long, 0);
    check("final_wr_pulses", wr_cnt, 1);
    check("final_rd_pulses", rd_cnt, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
